mem_port_arbiter: RTL

Arbitrates the single LSU data port of the memory stage between two requesters: the pipeline MEM stage (priority) and a debug/program-loader port. One access is in flight at a time. Each access is sequenced through a small FSM that holds address and controls for the LSU load latency and returns a one-cycle acknowledge. The block also produces the pipeline stall while a pipeline request is pending. It sits between the execute/memory pipeline register outputs and the `lsu` instance.

---
 rtl/mem_port_arbiter_if.sv | 54 +++++
 rtl/mem_port_arbiter.sv | 131 +++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if
// Bundles every request, response and LSU signal of the memory-port arbiter.
//   pipe side : i_pipe_req/wren/addr/st_data/slt_sl in, o_pipe_ack/ld_data/stall out
//   dbg side  : i_dbg_req/wren/addr/st_data/slt_sl in, o_dbg_ack/ld_data out
//   lsu side  : o_lsu_wren/addr/st_data/slt_sl out, i_lsu_ld_data in
//   status    : o_busy out
// Modport slave is the arbiter's view. Modport master is the view of the
// surrounding logic that drives the requests and plays the LSU.
interface mem_port_arbiter_if;
    logic        i_pipe_req;
    logic        i_pipe_wren;
    logic [31:0] i_pipe_addr;
    logic [31:0] i_pipe_st_data;
    logic [2:0]  i_pipe_slt_sl;
    logic        o_pipe_ack;
    logic [31:0] o_pipe_ld_data;
    logic        o_pipe_stall;

    logic        i_dbg_req;
    logic        i_dbg_wren;
    logic [31:0] i_dbg_addr;
    logic [31:0] i_dbg_st_data;
    logic [2:0]  i_dbg_slt_sl;
    logic        o_dbg_ack;
    logic [31:0] o_dbg_ld_data;

    logic        o_lsu_wren;
    logic [31:0] o_lsu_addr;
    logic [31:0] o_lsu_st_data;
    logic [2:0]  o_lsu_slt_sl;
    logic [31:0] i_lsu_ld_data;

    logic        o_busy;

    modport slave (
        input  i_pipe_req, i_pipe_wren, i_pipe_addr, i_pipe_st_data, i_pipe_slt_sl,
        output o_pipe_ack, o_pipe_ld_data, o_pipe_stall,
        input  i_dbg_req, i_dbg_wren, i_dbg_addr, i_dbg_st_data, i_dbg_slt_sl,
        output o_dbg_ack, o_dbg_ld_data,
        output o_lsu_wren, o_lsu_addr, o_lsu_st_data, o_lsu_slt_sl,
        input  i_lsu_ld_data,
        output o_busy
    );

    modport master (
        output i_pipe_req, i_pipe_wren, i_pipe_addr, i_pipe_st_data, i_pipe_slt_sl,
        input  o_pipe_ack, o_pipe_ld_data, o_pipe_stall,
        output i_dbg_req, i_dbg_wren, i_dbg_addr, i_dbg_st_data, i_dbg_slt_sl,
        input  o_dbg_ack, o_dbg_ld_data,
        input  o_lsu_wren, o_lsu_addr, o_lsu_st_data, o_lsu_slt_sl,
        output i_lsu_ld_data,
        input  o_busy
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares the single LSU data port between the pipeline MEM stage (priority)
// and the debug/program-loader port, one access at a time. Each access runs
// IDLE -> ACCESS (1 cycle store, LD_LAT cycles load) -> RESP (ack pulse).
// A starvation counter forces a debug grant after STARVE_MAX lost rounds.
// Ports:
//   i_clk     : clock, rising edge
//   i_reset_n : asynchronous active-low reset
//   bus       : mem_port_arbiter_if.slave (requests, acks, load data, LSU, busy)
module mem_port_arbiter #(
    parameter int LD_LAT     = 1,
    parameter int STARVE_MAX = 8
) (
    input  logic              i_clk,
    input  logic              i_reset_n,
    mem_port_arbiter_if.slave bus
);
    localparam int              SC_W     = $clog2(STARVE_MAX + 1);
    localparam logic [3:0]      LAST_CYC = 4'(LD_LAT - 1);
    localparam logic [SC_W-1:0] SC_MAX   = SC_W'(STARVE_MAX);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic            owner_dbg;
    logic            wren_q;
    logic [31:0]     addr_q;
    logic [31:0]     st_data_q;
    logic [2:0]      slt_sl_q;
    logic [3:0]      acc_cnt;
    logic [SC_W-1:0] starve_cnt;
    logic [31:0]     pipe_ld_q;
    logic [31:0]     dbg_ld_q;
    logic            any_req;
    logic            grant_dbg;
    logic            acc_done;
    logic            pipe_ack;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        any_req   = bus.i_pipe_req | bus.i_dbg_req;
        // Debug wins when it is alone or when the pipe has starved it long enough.
        grant_dbg = bus.i_dbg_req & (~bus.i_pipe_req | (starve_cnt == SC_MAX));
        // A store always finishes in one ACCESS cycle; a load after LD_LAT cycles.
        acc_done  = wren_q | (acc_cnt == LAST_CYC);
        case (state)
            IDLE:    if (any_req) state_nxt = ACCESS;
            ACCESS:  if (acc_done) state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            owner_dbg  <= 1'b0;
            wren_q     <= 1'b0;
            addr_q     <= '0;
            st_data_q  <= '0;
            slt_sl_q   <= '0;
            acc_cnt    <= '0;
            starve_cnt <= '0;
            pipe_ld_q  <= '0;
            dbg_ld_q   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    acc_cnt <= '0;
                    if (any_req) begin
                        owner_dbg <= grant_dbg;
                        if (grant_dbg) begin
                            wren_q    <= bus.i_dbg_wren;
                            addr_q    <= bus.i_dbg_addr;
                            st_data_q <= bus.i_dbg_st_data;
                            slt_sl_q  <= bus.i_dbg_slt_sl;
                        end else begin
                            wren_q    <= bus.i_pipe_wren;
                            addr_q    <= bus.i_pipe_addr;
                            st_data_q <= bus.i_pipe_st_data;
                            slt_sl_q  <= bus.i_pipe_slt_sl;
                        end
                    end
                    // Reaching the else-if means both requested and the pipe won.
                    if (!bus.i_dbg_req || grant_dbg) begin
                        starve_cnt <= '0;
                    end else if (starve_cnt != SC_MAX) begin
                        starve_cnt <= starve_cnt + 1'b1;
                    end
                end
                ACCESS: begin
                    acc_cnt <= acc_cnt + 1'b1;
                    if (acc_done && !wren_q) begin
                        if (owner_dbg) begin
                            dbg_ld_q <= bus.i_lsu_ld_data;
                        end else begin
                            pipe_ld_q <= bus.i_lsu_ld_data;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Strobes are decoded from state so an asynchronous reset kills them at once.
    assign pipe_ack           = (state == RESP) & ~owner_dbg;
    assign bus.o_pipe_ack     = pipe_ack;
    assign bus.o_dbg_ack      = (state == RESP) & owner_dbg;
    assign bus.o_pipe_stall   = bus.i_pipe_req & ~pipe_ack;
    assign bus.o_pipe_ld_data = pipe_ld_q;
    assign bus.o_dbg_ld_data  = dbg_ld_q;
    assign bus.o_lsu_wren     = (state == ACCESS) & wren_q;
    assign bus.o_lsu_addr     = addr_q;
    assign bus.o_lsu_st_data  = st_data_q;
    assign bus.o_lsu_slt_sl   = slt_sl_q;
    assign bus.o_busy         = (state != IDLE);
endmodule
